multicycle_control: RTL and testbench

Multicycle control unit for the 32-bit datapath. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the ALU-side control pair (`ALUOp`, `FuncCode`) that the ALU control decoder consumes, and closes the loop on the ALU `Zero` result for branches. It sits between the instruction register and the datapath muxes, register file and memory port, and adds a ready handshake so memory may insert wait states.

---
 rtl/multicycle_control_pkg.sv | 56 +++++
 rtl/multicycle_control_decode.sv | 68 ++++++
 rtl/multicycle_control.sv | 73 +++++++
 tb/tb_multicycle_control.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: opcodes, ALUOp codes, state encodings and control vector for the multicycle controller.
package multicycle_control_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_JMP    = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       pc_en;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       illegal;
    } ctrl_t;

    // State following DECODE; unknown opcodes fall back to FETCH.
    function automatic state_t decode_op(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return S_RTEX;
            OP_LW, OP_SW: return S_MEMADR;
            OP_BEQ:       return S_BEQ;
            OP_J:         return S_JMP;
            OP_ADDI:      return S_ADDIEX;
            default:      return S_FETCH;
        endcase
    endfunction
endpackage

// File: rtl/multicycle_control_decode.sv
// control_decode: combinational map from state, Zero and MemReady to the control vector.
module control_decode
    import multicycle_control_pkg::*;
(
    input  logic       i_en,
    input  logic [3:0] i_state,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output ctrl_t      o_ctrl
);
    ctrl_t w_c;

    always_comb begin
        w_c = '0;
        case (i_state)
            S_FETCH: begin
                w_c.mem_read  = 1'b1;
                w_c.alu_src_b = 2'b01;
                w_c.ir_write  = i_mem_ready;
                w_c.pc_en     = i_mem_ready;
            end
            S_DECODE: begin
                w_c.alu_src_b = 2'b11;
                w_c.illegal   = decode_op(i_op) == S_FETCH;
            end
            S_MEMADR, S_ADDIEX: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_c.mem_read = 1'b1;
                w_c.iord     = 1'b1;
            end
            S_MEMWB: begin
                w_c.reg_write  = 1'b1;
                w_c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                w_c.mem_write = 1'b1;
                w_c.iord      = 1'b1;
            end
            S_RTEX: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                w_c.reg_write = 1'b1;
                w_c.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                w_c.alu_src_a = 1'b1;
                w_c.alu_op    = ALU_SUB;
                w_c.pc_source = 2'b01;
                w_c.pc_en     = i_zero;
            end
            S_JMP: begin
                w_c.pc_source = 2'b10;
                w_c.pc_en     = 1'b1;
            end
            S_ADDIWB: w_c.reg_write = 1'b1;
            default: ;
        endcase
    end

    // Reset quiets every strobe and select, including FETCH's defaults.
    assign o_ctrl = i_en ? w_c : '0;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: five-phase instruction sequencer with memory ready handshake.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    input  logic       i_mem_ready,
    output logic [1:0] o_alu_op,
    output logic [3:0] o_func_code,
    output logic       o_pc_en,
    output logic [1:0] o_pc_source,
    output logic       o_iord,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [3:0] o_state,
    output logic       o_illegal
);
    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = decode_op(i_op);
            S_MEMADR: w_next = (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = i_mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = i_mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   w_next = S_RTWB;
            S_ADDIEX: w_next = S_ADDIWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_FETCH;
        else        r_state <= w_next;

    control_decode u_decode (
        .i_en        (rst_n),
        .i_state     (r_state),
        .i_op        (i_op),
        .i_zero      (i_zero),
        .i_mem_ready (i_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    assign o_alu_op     = w_ctrl.alu_op;
    assign o_func_code  = i_funct[3:0];
    assign o_pc_en      = w_ctrl.pc_en;
    assign o_pc_source  = w_ctrl.pc_source;
    assign o_iord       = w_ctrl.iord;
    assign o_mem_read   = w_ctrl.mem_read;
    assign o_mem_write  = w_ctrl.mem_write;
    assign o_ir_write   = w_ctrl.ir_write;
    assign o_reg_dst    = w_ctrl.reg_dst;
    assign o_mem_to_reg = w_ctrl.mem_to_reg;
    assign o_reg_write  = w_ctrl.reg_write;
    assign o_alu_src_a  = w_ctrl.alu_src_a;
    assign o_alu_src_b  = w_ctrl.alu_src_b;
    assign o_state      = r_state;
    assign o_illegal    = w_ctrl.illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed checks of sequencing, wait states, branches and reset.
module tb_multicycle_control;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic [1:0] alu_op, pc_source, alu_src_b;
    logic [3:0] func_code, state;
    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
    int         n_chk = 0;
    int         n_pass = 0;

    multicycle_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_op         (op),
        .i_funct      (funct),
        .i_zero       (zero),
        .i_mem_ready  (mem_ready),
        .o_alu_op     (alu_op),
        .o_func_code  (func_code),
        .o_pc_en      (pc_en),
        .o_pc_source  (pc_source),
        .o_iord       (iord),
        .o_mem_read   (mem_read),
        .o_mem_write  (mem_write),
        .o_ir_write   (ir_write),
        .o_reg_dst    (reg_dst),
        .o_mem_to_reg (mem_to_reg),
        .o_reg_write  (reg_write),
        .o_alu_src_a  (alu_src_a),
        .o_alu_src_b  (alu_src_b),
        .o_state      (state),
        .o_illegal    (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 1'b0; op = 6'd0; funct = 6'b100010; zero = 1'b0; mem_ready = 1'b1;
        #1;
        chk("rst_state", 8'(state), 8'd0);
        chk("rst_memread", 8'(mem_read), 8'd0);
        chk("rst_irwrite", 8'(ir_write), 8'd0);
        chk("rst_srcb", 8'(alu_src_b), 8'd0);
        chk("rst_funccode", 8'(func_code), 8'h2);
        tick;
        tick;
        rst_n = 1'b1;
        #1;
        // R-type: FETCH DECODE RTEX RTWB
        chk("r_fetch_state", 8'(state), 8'd0);
        chk("r_fetch_memread", 8'(mem_read), 8'd1);
        chk("r_fetch_irwrite", 8'(ir_write), 8'd1);
        chk("r_fetch_pcen", 8'(pc_en), 8'd1);
        chk("r_fetch_srcb", 8'(alu_src_b), 8'd1);
        tick;
        chk("r_decode_state", 8'(state), 8'd1);
        chk("r_decode_srcb", 8'(alu_src_b), 8'd3);
        chk("r_decode_illegal", 8'(illegal), 8'd0);
        tick;
        chk("r_ex_state", 8'(state), 8'd6);
        chk("r_ex_aluop", 8'(alu_op), 8'd2);
        chk("r_ex_funccode", 8'(func_code), 8'h2);
        chk("r_ex_srca", 8'(alu_src_a), 8'd1);
        tick;
        chk("r_wb_state", 8'(state), 8'd7);
        chk("r_wb_regwrite", 8'(reg_write), 8'd1);
        chk("r_wb_regdst", 8'(reg_dst), 8'd1);
        chk("r_wb_memtoreg", 8'(mem_to_reg), 8'd0);
        tick;
        chk("r_done_state", 8'(state), 8'd0);
        // lw with two wait cycles in MEMRD: 7 cycles
        op = 6'b100011;
        tick;
        tick;
        chk("lw_adr_state", 8'(state), 8'd2);
        chk("lw_adr_srcb", 8'(alu_src_b), 8'd2);
        chk("lw_adr_srca", 8'(alu_src_a), 8'd1);
        tick;
        mem_ready = 1'b0;
        #1;
        chk("lw_rd_state", 8'(state), 8'd3);
        chk("lw_rd_iord", 8'(iord), 8'd1);
        chk("lw_rd_memread", 8'(mem_read), 8'd1);
        chk("lw_rd_regwrite", 8'(reg_write), 8'd0);
        tick;
        chk("lw_wait1_state", 8'(state), 8'd3);
        tick;
        chk("lw_wait2_state", 8'(state), 8'd3);
        mem_ready = 1'b1;
        tick;
        chk("lw_wb_state", 8'(state), 8'd4);
        chk("lw_wb_regwrite", 8'(reg_write), 8'd1);
        chk("lw_wb_memtoreg", 8'(mem_to_reg), 8'd1);
        chk("lw_wb_regdst", 8'(reg_dst), 8'd0);
        tick;
        chk("lw_done_state", 8'(state), 8'd0);
        chk("lw_done_regwrite", 8'(reg_write), 8'd0);
        // beq taken then not taken, 3 cycles each
        op = 6'b000100; zero = 1'b1;
        tick;
        tick;
        chk("beq1_state", 8'(state), 8'd8);
        chk("beq1_pcen", 8'(pc_en), 8'd1);
        chk("beq1_pcsrc", 8'(pc_source), 8'd1);
        chk("beq1_aluop", 8'(alu_op), 8'd1);
        tick;
        chk("beq1_done", 8'(state), 8'd0);
        zero = 1'b0;
        tick;
        tick;
        chk("beq0_state", 8'(state), 8'd8);
        chk("beq0_pcen", 8'(pc_en), 8'd0);
        tick;
        chk("beq0_done", 8'(state), 8'd0);
        // j
        op = 6'b000010;
        tick;
        tick;
        chk("j_state", 8'(state), 8'd9);
        chk("j_pcsrc", 8'(pc_source), 8'd2);
        chk("j_pcen", 8'(pc_en), 8'd1);
        tick;
        chk("j_done", 8'(state), 8'd0);
        // addi
        op = 6'b001000;
        tick;
        tick;
        chk("addi_ex_state", 8'(state), 8'd10);
        chk("addi_ex_srcb", 8'(alu_src_b), 8'd2);
        chk("addi_ex_aluop", 8'(alu_op), 8'd0);
        tick;
        chk("addi_wb_state", 8'(state), 8'd11);
        chk("addi_wb_regwrite", 8'(reg_write), 8'd1);
        chk("addi_wb_regdst", 8'(reg_dst), 8'd0);
        tick;
        chk("addi_done", 8'(state), 8'd0);
        // illegal opcode
        op = 6'b111111;
        tick;
        chk("ill_state", 8'(state), 8'd1);
        chk("ill_pulse", 8'(illegal), 8'd1);
        chk("ill_regwrite", 8'(reg_write), 8'd0);
        chk("ill_memwrite", 8'(mem_write), 8'd0);
        tick;
        chk("ill_next", 8'(state), 8'd0);
        chk("ill_cleared", 8'(illegal), 8'd0);
        // FETCH wait state
        mem_ready = 1'b0;
        #1;
        chk("fw_irwrite", 8'(ir_write), 8'd0);
        chk("fw_pcen", 8'(pc_en), 8'd0);
        tick;
        chk("fw_hold", 8'(state), 8'd0);
        // sw interrupted by reset mid-MEMWR
        mem_ready = 1'b1; op = 6'b101011; funct = 6'b000111;
        tick;
        tick;
        tick;
        mem_ready = 1'b0;
        #1;
        chk("sw_wr_state", 8'(state), 8'd5);
        chk("sw_wr_memwrite", 8'(mem_write), 8'd1);
        chk("sw_wr_iord", 8'(iord), 8'd1);
        rst_n = 1'b0;
        #1;
        chk("sw_rst_state", 8'(state), 8'd0);
        chk("sw_rst_memwrite", 8'(mem_write), 8'd0);
        chk("sw_rst_memread", 8'(mem_read), 8'd0);
        chk("sw_rst_funccode", 8'(func_code), 8'h7);
        tick;
        chk("sw_rst_hold", 8'(state), 8'd0);
        rst_n = 1'b1; mem_ready = 1'b1;
        #1;
        chk("post_rst_memread", 8'(mem_read), 8'd1);
        chk("post_rst_iord", 8'(iord), 8'd0);
        tick;
        chk("post_rst_decode", 8'(state), 8'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
